// File: rtl/sensor_pkg.sv
// sensor_pkg: shared widths, FSM state encoding and the input clamp helper
// for the sensor_reader block.
package sensor_pkg;

  localparam int SAMPLE_W = 8;
  localparam int BCD_W    = 4;

  localparam logic [SAMPLE_W-1:0] SAMPLE_MAX = 8'd99;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_CONVERT = 2'd1;
  localparam state_t ST_PUBLISH = 2'd2;

  // The display only has two BCD digits, so anything above 99 saturates.
  function automatic logic [SAMPLE_W-1:0] clamp_sample(input logic [SAMPLE_W-1:0] v);
    return (v > SAMPLE_MAX) ? SAMPLE_MAX : v;
  endfunction

endpackage

// File: rtl/bcd_div10.sv
// bcd_div10: iterative divide-by-ten for values 0..99. One subtraction of ten
// per cycle; done is high in the cycle the remainder drops below ten, at which
// point tens/units are final and stay held until the next start.
module bcd_div10
  import sensor_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                start,
  input  logic [SAMPLE_W-1:0] value,
  output logic [BCD_W-1:0]    tens,
  output logic [BCD_W-1:0]    units,
  output logic                done
);

  localparam logic [SAMPLE_W-1:0] TEN = 8'd10;

  logic [SAMPLE_W-1:0] rem;
  logic                busy;

  // Load on start, then peel off one ten per cycle until the remainder is a digit.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rem  <= '0;
      tens <= '0;
      busy <= 1'b0;
    end else if (start) begin
      rem  <= value;
      tens <= '0;
      busy <= 1'b1;
    end else if (busy) begin
      if (rem >= TEN) begin
        rem  <= rem - TEN;
        tens <= tens + BCD_W'(1);
      end else begin
        busy <= 1'b0;
      end
    end
  end

  assign units = rem[BCD_W-1:0];
  assign done  = busy && (rem < TEN);

endmodule

// File: rtl/sensor_reader.sv
// sensor_reader: captures temperature/humidity samples, converts temperature
// to two BCD digits, and publishes with alarm, staleness and overrun status.
// A one-deep pending register absorbs samples arriving while busy.
// Build option: define SENSOR_READER_MINMAX_EN to track the lowest/highest
// published temperature; otherwise o_min/o_max are tied to zero.
//
// state      | meaning
// ST_IDLE    | waiting for i_valid, or draining a buffered pending sample
// ST_CONVERT | bcd_div10 subtracting tens from the latched temperature
// ST_PUBLISH | registering outputs, pulsing o_new, chaining into pending data
module sensor_reader
  import sensor_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 10_000_000,
  parameter int unsigned ALARM_THRESH   = 80
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [15:0] i_temp,
  input  logic [15:0] i_humid,
  input  logic        i_valid,
  output logic [3:0]  o_tens,
  output logic [3:0]  o_units,
  output logic [7:0]  o_humid,
  output logic [7:0]  o_min,
  output logic [7:0]  o_max,
  output logic        o_new,
  output logic        o_alarm,
  output logic        o_stale,
  output logic        o_overrun
);

  // TIMEOUT_CYCLES must be at least 2 for the staleness threshold to exist.
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SET  = CNT_W'(TIMEOUT_CYCLES - 2);

  state_t              state;
  logic [SAMPLE_W-1:0] in_temp;
  logic [SAMPLE_W-1:0] cur_temp;
  logic [SAMPLE_W-1:0] cur_humid;
  logic [SAMPLE_W-1:0] pend_temp;
  logic [SAMPLE_W-1:0] pend_humid;
  logic                pend_full;
  logic [CNT_W-1:0]    stale_cnt;

  logic                take_pend;
  logic                take_new;
  logic                pend_load;
  logic                div_start;
  logic [SAMPLE_W-1:0] div_value;
  logic [BCD_W-1:0]    div_tens;
  logic [BCD_W-1:0]    div_units;
  logic                div_done;

  // Only the low byte of each sensor word carries data.
  logic unused_hi;
  assign unused_hi = ^{i_temp[15:8], i_humid[15:8]};

  assign in_temp = clamp_sample(i_temp[7:0]);

  // Pending data always wins over a fresh sample when a conversion can start;
  // the fresh sample then drops into the freed pending slot.
  assign take_pend = pend_full && ((state == ST_IDLE) || (state == ST_PUBLISH));
  assign take_new  = i_valid && (state == ST_IDLE) && !pend_full;
  assign pend_load = i_valid && !take_new;
  assign div_start = take_pend || take_new;
  assign div_value = take_pend ? pend_temp : in_temp;

  bcd_div10 u_div (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .start (div_start),
    .value (div_value),
    .tens  (div_tens),
    .units (div_units),
    .done  (div_done)
  );

  // Sequencer: start a conversion, wait for the divider, publish, chain.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:    if (div_start) state <= ST_CONVERT;
        ST_CONVERT: if (div_done)  state <= ST_PUBLISH;
        ST_PUBLISH: state <= take_pend ? ST_CONVERT : ST_IDLE;
        default:    state <= ST_IDLE;
      endcase
    end
  end

  // Keep the clamped temperature and humidity of the sample being converted.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cur_temp  <= '0;
      cur_humid <= '0;
    end else if (div_start) begin
      cur_temp  <= div_value;
      cur_humid <= take_pend ? pend_humid : i_humid[7:0];
    end
  end

  // One-deep pending buffer; a new sample overwrites unconsumed pending data.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pend_full  <= 1'b0;
      pend_temp  <= '0;
      pend_humid <= '0;
    end else if (pend_load) begin
      pend_full  <= 1'b1;
      pend_temp  <= in_temp;
      pend_humid <= i_humid[7:0];
    end else if (take_pend) begin
      pend_full  <= 1'b0;
    end
  end

  // Register published values and the one-cycle o_new / o_overrun pulses.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_tens    <= '0;
      o_units   <= '0;
      o_humid   <= '0;
      o_alarm   <= 1'b0;
      o_new     <= 1'b0;
      o_overrun <= 1'b0;
    end else begin
      o_new     <= (state == ST_PUBLISH);
      o_overrun <= i_valid && pend_full && !take_pend;
      if (state == ST_PUBLISH) begin
        o_tens  <= div_tens;
        o_units <= div_units;
        o_humid <= cur_humid;
        o_alarm <= (32'(cur_temp) >= ALARM_THRESH);
      end
    end
  end

  // Cycles since the last i_valid, saturating at the timeout threshold.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      stale_cnt <= '0;
    end else if (i_valid) begin
      stale_cnt <= '0;
    end else if (stale_cnt != CNT_LAST) begin
      stale_cnt <= stale_cnt + CNT_W'(1);
    end
  end

  // Stale raises once as the count reaches its limit; a publish clears it.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_stale <= 1'b1;
    end else if (state == ST_PUBLISH) begin
      o_stale <= 1'b0;
    end else if (!i_valid && (stale_cnt == CNT_SET)) begin
      o_stale <= 1'b1;
    end
  end

`ifdef SENSOR_READER_MINMAX_EN
  // Track extremes of the published (clamped) temperature; ties change nothing.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_min <= SAMPLE_MAX;
      o_max <= '0;
    end else if (state == ST_PUBLISH) begin
      if (cur_temp < o_min) o_min <= cur_temp;
      if (cur_temp > o_max) o_max <= cur_temp;
    end
  end
`else
  assign o_min = '0;
  assign o_max = '0;
`endif

endmodule

// File: tb/tb_sensor_reader.sv
// tb_sensor_reader: directed and random stimulus against a transaction-timed
// reference model (publish time = start + tens + 2, one pending slot).
module tb_sensor_reader;

  localparam int TIMEOUT = 20;
  localparam int THRESH  = 80;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_valid;
  logic [15:0] i_temp;
  logic [15:0] i_humid;
  logic [3:0]  o_tens;
  logic [3:0]  o_units;
  logic [7:0]  o_humid;
  logic [7:0]  o_min;
  logic [7:0]  o_max;
  logic        o_new;
  logic        o_alarm;
  logic        o_stale;
  logic        o_overrun;

  sensor_reader #(
    .TIMEOUT_CYCLES (TIMEOUT),
    .ALARM_THRESH   (THRESH)
  ) dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_temp    (i_temp),
    .i_humid   (i_humid),
    .i_valid   (i_valid),
    .o_tens    (o_tens),
    .o_units   (o_units),
    .o_humid   (o_humid),
    .o_min     (o_min),
    .o_max     (o_max),
    .o_new     (o_new),
    .o_alarm   (o_alarm),
    .o_stale   (o_stale),
    .o_overrun (o_overrun)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_pass   = 0;
  int edge_n   = 0;

  // reference model state
  bit m_busy;
  int m_pub_edge;
  int m_cur_v, m_cur_h;
  bit m_pend_full;
  int m_pend_v, m_pend_h;
  int m_last_ref;

  int exp_tens, exp_units, exp_humid, exp_min, exp_max;
  bit exp_new, exp_alarm, exp_stale, exp_ovr;

  task automatic chk(input string tag, input int got, input int want);
    n_checks++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at edge %0d", tag, got, want, edge_n);
  endtask

  task automatic model_reset();
    m_busy      = 1'b0;
    m_pub_edge  = 0;
    m_cur_v     = 0;
    m_cur_h     = 0;
    m_pend_full = 1'b0;
    m_pend_v    = 0;
    m_pend_h    = 0;
    m_last_ref  = -1;
    edge_n      = 0;
    exp_tens    = 0;
    exp_units   = 0;
    exp_humid   = 0;
    exp_alarm   = 1'b0;
    exp_new     = 1'b0;
    exp_ovr     = 1'b0;
    exp_stale   = 1'b1;
    exp_max     = 0;
`ifdef SENSOR_READER_MINMAX_EN
    exp_min     = 99;
`else
    exp_min     = 0;
`endif
  endtask

  task automatic m_start(input int v, input int h);
    m_cur_v    = v;
    m_cur_h    = h;
    m_busy     = 1'b1;
    m_pub_edge = edge_n + v / 10 + 2;
  endtask

  task automatic m_publish();
    exp_tens  = m_cur_v / 10;
    exp_units = m_cur_v % 10;
    exp_humid = m_cur_h;
    exp_alarm = (m_cur_v >= THRESH);
`ifdef SENSOR_READER_MINMAX_EN
    if (m_cur_v < exp_min) exp_min = m_cur_v;
    if (m_cur_v > exp_max) exp_max = m_cur_v;
`endif
  endtask

  // Advance the model by one clock edge with the inputs sampled at that edge.
  task automatic model_edge(input bit v, input int t, input int h);
    int  tv, hv;
    bit  pub;
    tv = t & 255;
    if (tv > 99) tv = 99;
    hv = h & 255;
    exp_new = 1'b0;
    exp_ovr = 1'b0;
    pub = m_busy && (edge_n == m_pub_edge);
    if (pub) begin
      m_publish();
      exp_new = 1'b1;
      m_busy  = 1'b0;
    end
    if (!m_busy && m_pend_full) begin
      m_start(m_pend_v, m_pend_h);
      m_pend_full = 1'b0;
    end
    if (v) begin
      if (!m_busy && !pub) begin
        m_start(tv, hv);
      end else begin
        if (m_pend_full) exp_ovr = 1'b1;
        m_pend_v    = tv;
        m_pend_h    = hv;
        m_pend_full = 1'b1;
      end
    end
    if (exp_new) exp_stale = 1'b0;
    else if (!v && (edge_n - m_last_ref == TIMEOUT - 1)) exp_stale = 1'b1;
    if (v) m_last_ref = edge_n;
  endtask

  task automatic check_all();
    chk("o_new",     o_new,     exp_new);
    chk("o_overrun", o_overrun, exp_ovr);
    chk("o_stale",   o_stale,   exp_stale);
    chk("o_tens",    o_tens,    exp_tens);
    chk("o_units",   o_units,   exp_units);
    chk("o_humid",   o_humid,   exp_humid);
    chk("o_alarm",   o_alarm,   exp_alarm);
    chk("o_min",     o_min,     exp_min);
    chk("o_max",     o_max,     exp_max);
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input bit v, input int t, input int h);
    i_valid = v;
    i_temp  = t[15:0];
    i_humid = h[15:0];
    @(posedge i_clk);
    model_edge(v, t, h);
    #1;
    check_all();
    edge_n++;
    @(negedge i_clk);
    i_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 0, 0);
  endtask

  // Asynchronous reset: checked before any clock edge, released at a falling edge.
  task automatic do_reset();
    i_rst   = 1'b1;
    i_valid = 1'b0;
    model_reset();
    #1;
    check_all();
    @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
  endtask

  int bvals[6] = '{0, 9, 10, 99, 100, 255};

  initial begin
    i_rst   = 1'b0;
    i_valid = 1'b0;
    i_temp  = '0;
    i_humid = '0;
    #2;
    do_reset();

    // 55 / 50: publish 7 edges after capture, no alarm
    step(1'b1, 'h0037, 50);
    idle(10);
    // 200 clamps to 99 with alarm
    step(1'b1, 200, 7);
    idle(13);
    // min/max sequence
    step(1'b1, 30, 1);  idle(6);
    step(1'b1, 85, 2);  idle(12);
    step(1'b1, 10, 3);  idle(5);
    // digit boundaries and clamp edges
    foreach (bvals[i]) begin
      step(1'b1, bvals[i], i * 10);
      idle(13);
    end
    // three back-to-back samples: middle one overwritten
    step(1'b1, 99, 11);
    step(1'b1, 99, 22);
    step(1'b1, 99, 33);
    idle(30);
    // staleness after a single sample
    step(1'b1, 42, 4);
    idle(25);
    step(1'b1, 5, 6);
    idle(6);
    // reset three cycles into conversion of 90
    step(1'b1, 90, 9);
    idle(3);
    do_reset();
    idle(20);

    // random traffic at varying densities
    for (int blk = 0; blk < 8; blk++) begin
      int pdiv;
      pdiv = (blk % 3 == 0) ? 3 : ((blk % 3 == 1) ? 10 : 40);
      for (int i = 0; i < 200; i++) begin
        bit v;
        int t;
        int h;
        v = ($urandom_range(0, pdiv - 1) == 0);
        if ($urandom_range(0, 1) == 1) t = int'($urandom_range(0, 120));
        else t = int'($urandom_range(0, 65535));
        h = int'($urandom_range(0, 65535));
        step(v, t, h);
      end
    end
    idle(30);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
